skid_buffer: RTL and testbench

Single-stage, full-throughput valid/ready pipeline register with a one-entry skid register. It sits on any streaming interface between an ingress (`i_*`) producer and an egress (`e_*`) consumer, and breaks the combinational path on both data/valid and ready. Every output is a flop output. A back-pressure on `e_ready_i` never drops data, even though `i_ready_o` is registered.

---
 rtl/skid_buffer.sv | 93 +++++++++
 tb/tb_skid_buffer.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/skid_buffer.sv
// Full-throughput valid/ready pipeline stage with a one-entry skid register.
// All outputs come straight from flops, which cuts both the forward and the ready paths.
module skid_buffer #(
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_valid_i,
  input  logic [DATA_W-1:0] i_data_i,
  output logic              i_ready_o,
  input  logic              e_ready_i,
  output logic              e_valid_o,
  output logic [DATA_W-1:0] e_data_o
);

  typedef enum logic [1:0] {
    StEmpty = 2'b00,
    StBusy  = 2'b01,
    StFull  = 2'b10
  } state_e;

  state_e            r_state;
  state_e            w_state_d;
  logic              r_i_ready;
  logic              r_e_valid;
  logic [DATA_W-1:0] r_out;
  logic [DATA_W-1:0] r_skid;
  logic [DATA_W-1:0] w_out_d;
  logic [DATA_W-1:0] w_skid_d;
  logic              w_in_xfer;
  logic              w_out_xfer;
  logic              w_i_ready_d;
  logic              w_e_valid_d;

  assign w_in_xfer  = i_valid_i & r_i_ready;
  assign w_out_xfer = r_e_valid & e_ready_i;

  always_comb begin
    w_state_d = r_state;
    w_out_d   = r_out;
    w_skid_d  = r_skid;
    case (r_state)
      StEmpty: begin
        if (w_in_xfer) begin
          w_out_d   = i_data_i;
          w_state_d = StBusy;
        end
      end
      StBusy: begin
        if (w_in_xfer && w_out_xfer) begin
          w_out_d = i_data_i;
        end else if (w_in_xfer) begin
          w_skid_d  = i_data_i;
          w_state_d = StFull;
        end else if (w_out_xfer) begin
          w_state_d = StEmpty;
        end
      end
      StFull: begin
        if (w_out_xfer) begin
          w_out_d   = r_skid;
          w_state_d = StBusy;
        end
      end
      default: w_state_d = StEmpty;
    endcase
  end

  // Handshake outputs are registered copies of what the next state will decode to.
  assign w_e_valid_d = (w_state_d != StEmpty);
  assign w_i_ready_d = (w_state_d != StFull);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= StEmpty;
      r_out     <= '0;
      r_skid    <= '0;
      r_e_valid <= 1'b0;
      r_i_ready <= 1'b0;
    end else begin
      r_state   <= w_state_d;
      r_out     <= w_out_d;
      r_skid    <= w_skid_d;
      r_e_valid <= w_e_valid_d;
      r_i_ready <= w_i_ready_d;
    end
  end

  assign i_ready_o = r_i_ready;
  assign e_valid_o = r_e_valid;
  assign e_data_o  = r_out;

endmodule

// File: tb/tb_skid_buffer.sv
// Randomized bench for skid_buffer; a FIFO-of-words model predicts every handshake and payload.
module tb_skid_buffer;

  logic       clk;
  logic       reset;
  logic       i_valid_i;
  logic [7:0] i_data_i;
  logic       i_ready_o;
  logic       e_ready_i;
  logic       e_valid_o;
  logic [7:0] e_data_o;

  skid_buffer #(.DATA_W(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .i_valid_i (i_valid_i),
    .i_data_i  (i_data_i),
    .i_ready_o (i_ready_o),
    .e_ready_i (e_ready_i),
    .e_valid_o (e_valid_o),
    .e_data_o  (e_data_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_vec;
  int unsigned n_err;

  // Model: words held in arrival order, capacity two; ready is withheld until one edge after reset.
  logic [7:0] mdl_q[$];
  bit         mdl_armed;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit exp_ready();
    return reset && mdl_armed && (mdl_q.size() < 2);
  endfunction

  function automatic bit exp_valid();
    return reset && (mdl_q.size() > 0);
  endfunction

  // Drive one cycle: inputs after the edge, compare at the falling edge, advance model on the edge.
  task automatic step(input logic v, input logic [7:0] d, input logic er);
    bit in_x;
    bit out_x;
    i_valid_i = v;
    i_data_i  = d;
    e_ready_i = er;
    @(negedge clk);
    check_val("i_ready", 32'(i_ready_o), 32'(exp_ready()));
    check_val("e_valid", 32'(e_valid_o), 32'(exp_valid()));
    if (!reset) check_val("rst_data", 32'(e_data_o), 32'd0);
    else if (exp_valid()) check_val("e_data", 32'(e_data_o), 32'(mdl_q[0]));
    in_x  = v && exp_ready();
    out_x = er && exp_valid();
    @(posedge clk);
    if (!reset) begin
      mdl_q.delete();
      mdl_armed = 1'b0;
    end else begin
      if (out_x) void'(mdl_q.pop_front());
      if (in_x) mdl_q.push_back(d);
      mdl_armed = 1'b1;
    end
    #1;
  endtask

  initial begin
    n_vec     = 0;
    n_err     = 0;
    mdl_armed = 1'b0;
    i_valid_i = 1'b0;
    i_data_i  = '0;
    e_ready_i = 1'b0;
    reset     = 1'b1;
    #2 reset  = 1'b0;

    // Reset held with random inputs, then release.
    for (int i = 0; i < 4; i++) step(1'($urandom), 8'($urandom), 1'($urandom));
    reset = 1'b1;
    step(1'b1, 8'h11, 1'b0);  // first edge after release: nothing accepted yet
    check_val("rel_ready", 32'(i_ready_o), 32'd1);
    check_val("rel_valid", 32'(e_valid_o), 32'd0);

    // Back-pressure fill.
    step(1'b1, 8'd90, 1'b0);
    check_val("bp_data0", 32'(e_data_o), 32'd90);
    check_val("bp_valid", 32'(e_valid_o), 32'd1);
    step(1'b1, 8'd255, 1'b0);
    check_val("bp_full_ready", 32'(i_ready_o), 32'd0);
    check_val("bp_hold", 32'(e_data_o), 32'd90);
    step(1'b1, 8'd77, 1'b0);  // refused: buffer full
    check_val("bp_hold2", 32'(e_data_o), 32'd90);

    // Drain.
    step(1'b0, 8'd0, 1'b1);
    check_val("drain_data1", 32'(e_data_o), 32'd255);
    check_val("drain_ready", 32'(i_ready_o), 32'd1);
    step(1'b0, 8'd0, 1'b1);
    check_val("drain_empty", 32'(e_valid_o), 32'd0);

    // Streaming 1..20 at full rate.
    for (int i = 1; i <= 20; i++) begin
      step(1'b1, 8'(i), 1'b1);
      check_val("stream_data", 32'(e_data_o), 32'(i));
      check_val("stream_ready", 32'(i_ready_o), 32'd1);
    end
    step(1'b0, 8'd0, 1'b1);
    check_val("stream_end", 32'(e_valid_o), 32'd0);

    // Random stall traffic.
    for (int i = 0; i < 1000; i++)
      step(1'($urandom), 8'($urandom), 1'($urandom_range(0, 3) != 0));

    // Fill, then reset asynchronously mid-cycle.
    while (mdl_q.size() > 0) step(1'b0, 8'd0, 1'b1);
    step(1'b1, 8'hA5, 1'b0);
    step(1'b1, 8'h5A, 1'b0);
    check_val("pre_rst_full", 32'(i_ready_o), 32'd0);
    #2 reset = 1'b0;
    #1;
    check_val("async_valid", 32'(e_valid_o), 32'd0);
    check_val("async_ready", 32'(i_ready_o), 32'd0);
    check_val("async_data", 32'(e_data_o), 32'd0);
    mdl_q.delete();
    mdl_armed = 1'b0;
    @(posedge clk);
    #1;
    step(1'b1, 8'h33, 1'b1);
    reset = 1'b1;
    for (int i = 0; i < 50; i++)
      step(1'($urandom), 8'($urandom), 1'($urandom_range(0, 2) != 0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
